// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receiver and the transmitter.
//   - rx_state_e     : receiver FSM state encoding
//   - CLK_HZ_DEF     : default system clock frequency (Hz)
//   - BIT_RATE_DEF   : default line rate (bit/s)
//   - cycles_per_bit : clock cycles per serial bit (truncating division)
package uart_pkg;

   localparam int unsigned CLK_HZ_DEF   = 50000000;
   localparam int unsigned BIT_RATE_DEF = 9600;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

   function automatic int unsigned cycles_per_bit(input int unsigned clk_hz,
                                                  input int unsigned bit_rate);
      return clk_hz / bit_rate;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receive line.
// Two flops bring the asynchronous pin into the clk domain; a third flop
// remembers the previous synchronized level so a high->low transition can
// be flagged. All three flops reset to the idle (high) level so reset never
// manufactures a false start edge.
//   clk       : system clock
//   reset     : synchronous active-high reset
//   rxd_async : raw serial pin
//   rxd_sync  : synchronized line level
//   fall_edge : high for one cycle when the synchronized line goes 1 -> 0
module uart_rx_sync (
   input  logic clk,
   input  logic reset,
   input  logic rxd_async,
   output logic rxd_sync,
   output logic fall_edge
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic rxd_q,  rxd_d;

   always_comb begin
      meta_d = rxd_async;
      sync_d = meta_q;
      rxd_d  = sync_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         rxd_q  <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         rxd_q  <= rxd_d;
      end
   end

   assign rxd_sync  = sync_q;
   assign fall_edge = rxd_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 by default, LSB first.
// A start is a falling edge of the synchronized line seen in IDLE while
// enabled. Each bit is sampled at its midpoint; the received byte, a
// framing error or a line break is reported with a one-cycle pulse.
//   clk               : system clock
//   reset             : synchronous active-high reset
//   uart_rx_en        : gates only the IDLE -> START transition
//   uart_rxd          : asynchronous serial line, idles high
//   uart_rx_data      : last good byte, held until the next good frame
//   uart_rx_valid     : pulse, uart_rx_data just updated
//   uart_rx_frame_err : pulse, stop bit sampled low
//   uart_rx_break     : pulse, entire frame (stop included) sampled low
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_HZ       = CLK_HZ_DEF,
   parameter int unsigned BIT_RATE     = BIT_RATE_DEF,
   parameter int unsigned PAYLOAD_BITS = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    uart_rx_en,
   input  logic                    uart_rxd,
   output logic [PAYLOAD_BITS-1:0] uart_rx_data,
   output logic                    uart_rx_valid,
   output logic                    uart_rx_frame_err,
   output logic                    uart_rx_break
);

   localparam int unsigned CYCLES_PER_BIT = cycles_per_bit(CLK_HZ, BIT_RATE);
   localparam int unsigned CNT_W          = $clog2(CYCLES_PER_BIT);

   // The counter reads 0 in the cycle after the start edge, so the start
   // sample lands CYCLES_PER_BIT/2 cycles after the edge and every later
   // sample one full bit period after the previous one.
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CYCLES_PER_BIT/2 - 1);
   localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CYCLES_PER_BIT - 1);
   localparam logic [3:0]       BIT_LAST  = 4'(PAYLOAD_BITS - 1);

   if (CYCLES_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx: CLK_HZ/BIT_RATE must be at least 4");
   end

   logic rxd_sync;
   logic fall_edge;

   uart_rx_sync u_sync (
      .clk       (clk),
      .reset     (reset),
      .rxd_async (uart_rxd),
      .rxd_sync  (rxd_sync),
      .fall_edge (fall_edge)
   );

   rx_state_e               state_q, state_d;
   logic [CNT_W-1:0]        cnt_q,   cnt_d;
   logic [3:0]              bit_q,   bit_d;
   logic [PAYLOAD_BITS-1:0] shift_q, shift_d;
   logic [PAYLOAD_BITS-1:0] data_q,  data_d;
   logic                    valid_q, valid_d;
   logic                    ferr_q,  ferr_d;
   logic                    brk_q,   brk_d;
   logic                    pulse;

   // A new start is taken only from the cycle after a result pulse.
   assign pulse = valid_q | ferr_q | brk_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CNT_W'(1);
      bit_d   = bit_q;
      shift_d = shift_q;
      data_d  = data_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      brk_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (fall_edge && uart_rx_en && !pulse) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d = '0;
               // Line back high at mid start bit: treat as a glitch.
               state_d = rxd_sync ? ST_IDLE : ST_DATA;
            end
         end
         ST_DATA: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               shift_d = {rxd_sync, shift_q[PAYLOAD_BITS-1:1]};
               bit_d   = bit_q + 4'd1;
               if (bit_q == BIT_LAST) state_d = ST_STOP;
            end
         end
         ST_STOP: begin
            if (cnt_q == FULL_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (rxd_sync) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
               end else if (shift_q == '0) begin
                  brk_d = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         brk_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         brk_q   <= brk_d;
      end
   end

   assign uart_rx_data      = data_q;
   assign uart_rx_valid     = valid_q;
   assign uart_rx_frame_err = ferr_q;
   assign uart_rx_break     = brk_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 10 clocks per bit. Frames are driven from a vector
// table plus hand-written corner sequences; every expected pulse (kind,
// held data, cycle) is queued when its frame starts and checked by a
// monitor when the DUT pulses.
module tb_uart_rx;

   localparam int unsigned CLK_HZ   = 1000000;
   localparam int unsigned BIT_RATE = 100000;
   localparam int          C        = 10;
   localparam int          LAT      = 98;   // pin fall -> result pulse

   // pulse kind encoding: {break, frame_err, valid}
   localparam int K_NONE = 0;
   localparam int K_VAL  = 1;
   localparam int K_ERR  = 2;
   localparam int K_BRK  = 4;

   logic       clk;
   logic       reset;
   logic       uart_rx_en;
   logic       uart_rxd;
   logic [7:0] uart_rx_data;
   logic       uart_rx_valid;
   logic       uart_rx_frame_err;
   logic       uart_rx_break;

   uart_rx #(
      .CLK_HZ       (CLK_HZ),
      .BIT_RATE     (BIT_RATE),
      .PAYLOAD_BITS (8)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .uart_rx_en        (uart_rx_en),
      .uart_rxd          (uart_rxd),
      .uart_rx_data      (uart_rx_data),
      .uart_rx_valid     (uart_rx_valid),
      .uart_rx_frame_err (uart_rx_frame_err),
      .uart_rx_break     (uart_rx_break)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int         kind;
      logic [7:0] data;
      int         cyc;
   } exp_t;

   typedef struct {
      logic [7:0] data;
      bit         stop;
      bit         en;
      bit         drop_en;
      int         kind;
   } vec_t;

   exp_t       sb[$];
   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_data = 8'h00;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drives one frame starting now (just after a rising edge) and queues
   // the expected outcome. Data is unchanged by anything but a good frame.
   task automatic send(input logic [7:0] d, input bit stop,
                       input bit drop_en, input int kind);
      logic [9:0] fr;
      exp_t       e;
      fr = {stop, d, 1'b0};
      if (kind == K_VAL) last_data = d;
      if (kind != K_NONE) begin
         e.kind = kind;
         e.data = last_data;
         e.cyc  = cyc + LAT;
         sb.push_back(e);
      end
      for (int i = 0; i < 10; i++) begin
         uart_rxd = fr[i];
         if (drop_en && i == 4) uart_rx_en = 1'b0;
         idle(C);
      end
      uart_rxd = 1'b1;
   endtask

   exp_t m_e;
   int   m_kind;
   always @(negedge clk) begin
      if (uart_rx_valid || uart_rx_frame_err || uart_rx_break) begin
         m_kind = int'({uart_rx_break, uart_rx_frame_err, uart_rx_valid});
         if (sb.size() == 0) begin
            chk("unexpected_pulse", m_kind, K_NONE);
         end else begin
            m_e = sb.pop_front();
            chk("pulse_kind",  m_kind,            m_e.kind);
            chk("pulse_data",  int'(uart_rx_data), int'(m_e.data));
            chk("pulse_cycle", cyc,               m_e.cyc);
         end
      end
   end

   vec_t vecs[8];

   initial begin
      exp_t e;
      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, K_VAL};
      vecs[1] = '{8'h55, 1'b0, 1'b1, 1'b0, K_ERR};   // stop bit low
      vecs[2] = '{8'h12, 1'b1, 1'b0, 1'b0, K_NONE};  // receiver disabled
      vecs[3] = '{8'h34, 1'b1, 1'b1, 1'b0, K_VAL};
      vecs[4] = '{8'h56, 1'b1, 1'b1, 1'b1, K_VAL};   // en dropped mid-frame
      vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b0, K_VAL};   // all-zero data, good stop
      vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b0, K_VAL};
      vecs[7] = '{8'h01, 1'b0, 1'b1, 1'b0, K_ERR};

      reset      = 1'b1;
      uart_rx_en = 1'b0;
      uart_rxd   = 1'b1;
      idle(3);
      chk("reset_data",  int'(uart_rx_data),      0);
      chk("reset_valid", int'(uart_rx_valid),     0);
      chk("reset_ferr",  int'(uart_rx_frame_err), 0);
      chk("reset_brk",   int'(uart_rx_break),     0);
      reset = 1'b0;
      idle(5);

      for (int i = 0; i < 8; i++) begin
         uart_rx_en = vecs[i].en;
         send(vecs[i].data, vecs[i].stop, vecs[i].drop_en, vecs[i].kind);
         idle(15);
         chk("held_data", int'(uart_rx_data), int'(last_data));
      end

      // back-to-back frames with no idle gap
      uart_rx_en = 1'b1;
      send(8'h3C, 1'b1, 1'b0, K_VAL);
      send(8'hFF, 1'b1, 1'b0, K_VAL);
      idle(15);

      // 3-cycle low glitch: must fall back to IDLE silently
      uart_rxd = 1'b0;
      idle(3);
      uart_rxd = 1'b1;
      idle(120);
      chk("glitch_data", int'(uart_rx_data), int'(last_data));

      // line break: one break pulse, then nothing while the line stays low
      e.kind = K_BRK;
      e.data = last_data;
      e.cyc  = cyc + LAT;
      sb.push_back(e);
      uart_rxd = 1'b0;
      idle(200);
      uart_rxd = 1'b1;
      idle(20);
      chk("break_data", int'(uart_rx_data), int'(last_data));

      // reset during bit 4 of 0x99; transmitter then abandons the frame
      uart_rxd = 1'b0;
      idle(C);
      for (int b = 0; b < 4; b++) begin
         uart_rxd = (b == 0 || b == 3);   // bits 0..3 of 0x99 = 1,0,0,1
         idle(C);
      end
      uart_rxd = 1'b1;
      idle(5);
      reset = 1'b1;
      idle(1);
      reset = 1'b0;
      last_data = 8'h00;
      chk("midreset_data",  int'(uart_rx_data),      0);
      chk("midreset_valid", int'(uart_rx_valid),     0);
      chk("midreset_ferr",  int'(uart_rx_frame_err), 0);
      chk("midreset_brk",   int'(uart_rx_break),     0);
      idle(150);
      chk("post_reset_data", int'(uart_rx_data), 0);

      send(8'h81, 1'b1, 1'b0, K_VAL);
      idle(20);

      chk("queue_drained", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive-side counterpart of the design's UART transmitter. Frame format is 8N1, LSB first.
- Takes the asynchronous serial line, synchronizes it, detects the start bit and samples each bit at its midpoint.
- Delivers the received byte with a one-cycle valid strobe. Also flags framing errors and line breaks.
- Sits between a user IO input pin and the operand latches, so A and B operands can arrive over serial instead of parallel pins.

Parameters:
- CLK_HZ, 50000000, system clock frequency in Hz.
- BIT_RATE, 9600, line rate in bit/s.
- PAYLOAD_BITS, 8, data bits per frame.
- CYCLES_PER_BIT, CLK_HZ/BIT_RATE, derived localparam. Must be >= 4. Integer division truncates.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- uart_rx_en  input  1  receiver enable; when low, no new frame is started.
- uart_rxd  input  1  asynchronous serial line; idle level is high.
- uart_rx_data  output  PAYLOAD_BITS  last received byte; held until the next valid frame.
- uart_rx_valid  output  1  one-cycle pulse: uart_rx_data has just been updated.
- uart_rx_frame_err  output  1  one-cycle pulse: stop bit was sampled low.
- uart_rx_break  output  1  one-cycle pulse: the whole frame, including the stop bit, was sampled low.

Behaviour:
- Reset: all outputs are 0, the FSM goes to IDLE, counters are 0, and both synchronizer flops are set to 1. Reset asserted mid-frame aborts the frame and produces no pulse.
- Input path: 2-flop synchronizer, then a third flop (rxd_q) that holds the previous synchronized value. A start is the falling edge: rxd_q = 1 and synchronized value = 0. A line held low continuously therefore never starts a second frame.
- Let S be the cycle in which the falling edge is seen in IDLE with uart_rx_en = 1. Sample k is taken at cycle S + CYCLES_PER_BIT/2 + k*CYCLES_PER_BIT, where:
  - k = 0 is the start bit;
  - k = 1 to PAYLOAD_BITS are the data bits;
  - k = PAYLOAD_BITS+1 is the stop bit.
- FSM states IDLE, START, DATA, STOP:
  - IDLE -> START on a qualified falling edge; the cycle counter clears.
  - START: at sample 0, if the line is low go to DATA; if high it was a glitch, so return to IDLE with no pulse.
  - DATA: shift each sample into the MSB of the shift register (LSB-first line order). After PAYLOAD_BITS samples go to STOP.
  - STOP, at the stop sample:
    - line high: on the next cycle uart_rx_data <= shift register and uart_rx_valid = 1;
    - line low with shift register all zero: uart_rx_break = 1;
    - line low otherwise: uart_rx_frame_err = 1.
  - Data is not updated on a frame error or a break. The FSM returns to IDLE in the same cycle as the pulse.
- A new start edge is accepted from the cycle after the pulse. Back-to-back frames with no idle gap must be received.
- uart_rx_en deasserted mid-frame: the current frame completes normally. uart_rx_en only gates the IDLE -> START transition.
- At most one of valid, frame_err and break is high in any cycle.
- Counter width is clog2(CYCLES_PER_BIT). The bit index counter is 4 bits and needs no wrap-around handling.

Decomposition:
- A shared package uart_pkg holds:
  - the FSM state enum (IDLE, START, DATA, STOP);
  - the default CLK_HZ and BIT_RATE constants, shared with the transmitter;
  - a CYCLES_PER_BIT helper function.
- One sub-module, uart_rx_sync: the 2-flop synchronizer plus the edge-detect flop. It outputs rxd_sync and fall_edge. Everything else stays flat in uart_rx.

Test Plan (CLK_HZ=1000000, BIT_RATE=100000, so CYCLES_PER_BIT=10):
- Send 0xA5 as 8N1 with en=1 -> exactly one valid pulse, data = 0xA5, 2+5+90+1 = 98 cycles after the pin falls; no err or break.
- Send 0x3C then 0xFF back-to-back, no idle gap -> two valid pulses 100 cycles apart, data 0x3C then 0xFF.
- Low glitch on the pin lasting 3 cycles -> FSM returns to IDLE, no pulses, data unchanged.
- Frame 0x55 with the stop bit driven low -> frame_err pulse, valid stays 0, data keeps its previous value. Hold the line low for 200 cycles -> break pulse, and no further frames while the line stays low.
- en=0 while sending 0x12 -> no pulses. Then en=1 and send 0x34 -> valid with data 0x34. Drop en to 0 mid-frame on 0x56 -> valid with data 0x56 is still produced.
- Assert reset for 1 cycle at bit 4 of frame 0x99 -> all outputs 0, no pulse. The next frame, 0x81, is received correctly.
